keyled_pio_key_in: RTL

- Avalon-MM slave input PIO. It reads the active-low push-buttons (or switches) into the SOPC system.
- It is the reader-side counterpart to the system's output PIOs that drive LEDs and 7-segment displays.
- Per-bit datapath: synchronisation, debounce, edge capture and a maskable level interrupt to the Nios II.
- Zero-wait-state, read-latency-0 slave on the system interconnect.

---
 rtl/keyled_pio_pkg.sv | 26 ++
 rtl/keyled_debounce.sv | 71 +++++++
 rtl/keyled_pio_key_in.sv | 122 ++++++++++++
 3 files changed

// File: rtl/keyled_pio_pkg.sv
// ---------------------------------------------------------------------------
// keyled_pio_pkg
//   Shared definitions for the push-button input PIO.
//   - Register word addresses on the Avalon-MM slave.
//   - Encodings of the edge that sets an edgecapture bit.
//   - Prescaler width helper (clog2 of the divider, never below 1).
// ---------------------------------------------------------------------------
package keyled_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_FALL = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // A divider of 1 or 2 still needs a one-bit counter.
    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/keyled_debounce.sv
// ---------------------------------------------------------------------------
// keyled_debounce
//   Synchroniser, sample-tick prescaler and two-sample debouncer for a
//   WIDTH-bit vector of asynchronous pins.
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     in_port  in   raw asynchronous pins
//     deb      out  debounced vector (registered)
// ---------------------------------------------------------------------------
module keyled_debounce
    import keyled_pio_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TICK_DIV   = 50000,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] deb
);

    localparam int               PW   = presc_width(TICK_DIV);
    localparam logic [PW-1:0]    LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic             tick;
    logic [WIDTH-1:0] agree;

    always_comb begin
        // With TICK_DIV = 1 the counter stays at 0, which equals LAST,
        // so every cycle is a tick.
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + PW'(1);

        s1_d = in_port;
        s2_d = s1_q;

        // A bit follows the pin only when this tick's sample matches the
        // previous tick's sample; otherwise it keeps its old value.
        agree    = ~(s2_q ^ sample_q);
        sample_d = tick ? s2_q : sample_q;
        deb_d    = tick ? ((s2_q & agree) | (deb_q & ~agree)) : deb_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= IDLE;
            s2_q     <= IDLE;
            sample_q <= IDLE;
            deb_q    <= IDLE;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            sample_q <= sample_d;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/keyled_pio_key_in.sv
// ---------------------------------------------------------------------------
// keyled_pio_key_in
//   Avalon-MM input PIO for active-low push-buttons/switches. Pins are
//   synchronised and debounced, a selectable edge sets a sticky
//   edgecapture bit, and masked capture bits raise a level interrupt.
//   Zero wait states, read latency 0.
//
//   Register map (word address):
//     0 data        RO   debounced pin value
//     1 reserved         reads 0, writes ignored
//     2 irqmask     RW   WIDTH bits
//     3 edgecapture R/W1C
//
//   Ports:
//     clk         in   system clock
//     reset_n     in   asynchronous active-low reset
//     address     in   word address
//     chipselect  in   slave select
//     write_n     in   active-low write strobe
//     writedata   in   write data (bits above WIDTH ignored)
//     in_port     in   raw asynchronous pins
//     readdata    out  combinational read data, zero-extended
//     irq         out  active-high level interrupt
// ---------------------------------------------------------------------------
module keyled_pio_key_in
    import keyled_pio_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int EDGE_TYPE  = 0,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic [31:0]      unused_wd;

    // Only the low WIDTH bits of writedata are meaningful.
    assign unused_wd = writedata;

    keyled_debounce #(
        .WIDTH      (WIDTH),
        .TICK_DIV   (TICK_DIV),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .deb     (deb)
    );

    always_comb begin
        if (EDGE_TYPE == int'(EDGE_RISE)) begin
            edge_det = ~deb_dly_q & deb;
        end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
            edge_det = deb_dly_q ^ deb;
        end else begin
            edge_det = deb_dly_q & ~deb;
        end
    end

    always_comb begin
        wr_en     = chipselect && !write_n;
        deb_dly_d = deb;

        irqmask_d = irqmask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end

        clr = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clr = writedata[WIDTH-1:0];
        end

        // OR-ing the edge in after the clear lets a simultaneous edge win.
        edgecap_d = (edgecap_q & ~clr) | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_dly_q <= IDLE;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            deb_dly_q <= deb_dly_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Read path is purely combinational and side-effect free.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = deb;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule
